// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: 7-segment controller with valid/ready input, blank/blink/leading-zero control
// and either static per-digit segment buses or a scanned bus with one-hot digit selects.
module hex_display_ctrl #(
    parameter int DIGITS     = 6,
    parameter int BLINK_DIV  = 24,
    parameter int SCAN_DIV   = 16,
    parameter bit ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] in_value,
    input  logic [DIGITS-1:0]   in_blank_mask,
    input  logic [DIGITS-1:0]   in_blink_mask,
    input  logic                lz_blank,
    input  logic                mode_scan,
    output logic [7*DIGITS-1:0] seg_out,
    output logic [6:0]          scan_seg,
    output logic [DIGITS-1:0]   scan_sel
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [6:0] DARK = ACTIVE_LOW ? 7'h7f : 7'h00;

    function automatic logic [6:0] encode(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'b1000000;
            4'h1: p = 7'b1111001;
            4'h2: p = 7'b0100100;
            4'h3: p = 7'b0110000;
            4'h4: p = 7'b0011001;
            4'h5: p = 7'b0010010;
            4'h6: p = 7'b0000010;
            4'h7: p = 7'b1011000;
            4'h8: p = 7'b0000000;
            4'h9: p = 7'b0010000;
            4'ha: p = 7'b0001000;
            4'hb: p = 7'b0000011;
            4'hc: p = 7'b1000110;
            4'hd: p = 7'b0100001;
            4'he: p = 7'b0000110;
            default: p = 7'b0001110;
        endcase
        return ACTIVE_LOW ? p : ~p;
    endfunction

    logic [4*DIGITS-1:0] disp_value, pend_value;
    logic [DIGITS-1:0]   disp_blank, disp_blink, pend_blank, pend_blink;
    logic                pend_full;
    logic [BLINK_DIV-1:0] blink_cnt;
    logic [SCAN_DIV-1:0]  scan_cnt;
    logic [IW-1:0]        digit_idx;
    logic [DIGITS-1:0]    sel_q;
    logic                 scan_en_q;
    logic [6:0]           digit_seg [DIGITS];
    logic [7*DIGITS-1:0]  seg_all;
    logic                 hi_zero;

    wire blink_phase = blink_cnt[BLINK_DIV-1];
    wire scan_wrap   = &scan_cnt;
    wire last_digit  = digit_idx == IW'(DIGITS - 1);
    wire accept      = in_valid & in_ready;
    // In scan mode the displayed set only changes as the index wraps, so a frame never mixes old and new data.
    wire apply       = pend_full & (~mode_scan | (scan_wrap & last_digit));

    assign in_ready = ~pend_full;
    // While in reset the select follows the live mode so scan boards see digit 0 selected.
    assign scan_sel = (reset_n ? scan_en_q : mode_scan) ? sel_q : '0;

    always_comb begin
        hi_zero = 1'b1;
        seg_all = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hi_zero = hi_zero & (disp_value[4*i +: 4] == 4'h0);
            digit_seg[i] = (disp_blank[i] | (disp_blink[i] & blink_phase) | (lz_blank & hi_zero & (i != 0)))
                         ? DARK : encode(disp_value[4*i +: 4]);
            seg_all[7*i +: 7] = digit_seg[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_value <= '0;
            disp_blank <= '1;
            disp_blink <= '0;
            pend_value <= '0;
            pend_blank <= '0;
            pend_blink <= '0;
            pend_full  <= 1'b0;
            blink_cnt  <= '0;
            scan_cnt   <= '0;
            digit_idx  <= '0;
            sel_q      <= DIGITS'(1);
            scan_en_q  <= 1'b0;
            seg_out    <= {DIGITS{DARK}};
            scan_seg   <= DARK;
        end else begin
            blink_cnt <= blink_cnt + BLINK_DIV'(1);
            scan_cnt  <= scan_cnt + SCAN_DIV'(1);
            if (scan_wrap)
                digit_idx <= last_digit ? '0 : digit_idx + IW'(1);
            if (accept) begin
                pend_value <= in_value;
                pend_blank <= in_blank_mask;
                pend_blink <= in_blink_mask;
                pend_full  <= 1'b1;
            end else if (apply) begin
                disp_value <= pend_value;
                disp_blank <= pend_blank;
                disp_blink <= pend_blink;
                pend_full  <= 1'b0;
            end
            seg_out   <= mode_scan ? {DIGITS{DARK}} : seg_all;
            scan_seg  <= mode_scan ? digit_seg[digit_idx] : DARK;
            sel_q     <= DIGITS'(1) << digit_idx;
            scan_en_q <= mode_scan;
        end
    end
endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: per-cycle scoreboard from a behavioural model plus directed checks.
module tb_hex_display_ctrl;
    localparam int D = 6;
    localparam logic [6:0] DK = 7'h7f;
    localparam logic [6:0] ENC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};

    logic        clk = 0, reset_n = 0, in_valid = 0, lz_blank = 0, mode_scan = 0;
    logic        in_ready;
    logic [23:0] in_value = '0;
    logic [5:0]  in_blank_mask = '0, in_blink_mask = '0;
    logic [41:0] seg_out;
    logic [6:0]  scan_seg;
    logic [5:0]  scan_sel;
    int          checks = 0, errors = 0;

    typedef struct {
        logic [41:0] seg;
        logic [6:0]  sseg;
        logic [5:0]  ssel;
        logic        rdy;
    } exp_t;
    exp_t q[$];

    logic [23:0] m_val, p_val;
    logic [5:0]  m_blank, m_blink, p_blank, p_blink;
    logic        p_full;
    int          bcnt, scnt, idx;

    hex_display_ctrl #(.DIGITS(D), .BLINK_DIV(4), .SCAN_DIV(2), .ACTIVE_LOW(1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .in_blank_mask(in_blank_mask), .in_blink_mask(in_blink_mask),
        .lz_blank(lz_blank), .mode_scan(mode_scan), .seg_out(seg_out),
        .scan_seg(scan_seg), .scan_sel(scan_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] mdig(int d);
        int h = 0;
        for (int k = 0; k < D; k++)
            if (m_val[4*k +: 4] != 4'h0) h = k;
        if (m_blank[d] || (m_blink[d] && bcnt >= 8) || (lz_blank && d > h)) return DK;
        return ENC[m_val[4*d +: 4]];
    endfunction

    function automatic int sel_idx(logic [5:0] s);
        int r = 0;
        for (int k = 0; k < D; k++)
            if (s[k]) r = k;
        return r;
    endfunction

    task automatic model_reset();
        m_val = '0; m_blank = '1; m_blink = '0;
        p_val = '0; p_blank = '0; p_blink = '0; p_full = 0;
        bcnt = 0; scnt = 0; idx = 0;
        q.delete();
    endtask

    initial begin
        model_reset();
        forever begin
            exp_t e;
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else begin
                for (int d = 0; d < D; d++) e.seg[7*d +: 7] = mode_scan ? DK : mdig(d);
                e.sseg = mode_scan ? mdig(idx) : DK;
                e.ssel = mode_scan ? 6'(1 << idx) : 6'b0;
                if (in_valid && !p_full) begin
                    p_val = in_value; p_blank = in_blank_mask; p_blink = in_blink_mask; p_full = 1;
                end else if (p_full && (!mode_scan || (scnt == 3 && idx == D - 1))) begin
                    m_val = p_val; m_blank = p_blank; m_blink = p_blink; p_full = 0;
                end
                if (scnt == 3) idx = (idx + 1) % D;
                scnt = (scnt + 1) % 4;
                bcnt = (bcnt + 1) % 16;
                e.rdy = !p_full;
                q.push_back(e);
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (reset_n && q.size() > 0) begin
            e = q.pop_front();
            check("mon_seg_out", 64'(seg_out), 64'(e.seg));
            check("mon_scan_seg", 64'(scan_seg), 64'(e.sseg));
            check("mon_scan_sel", 64'(scan_sel), 64'(e.ssel));
            check("mon_in_ready", 64'(in_ready), 64'(e.rdy));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] v, input logic [5:0] b, input logic [5:0] k);
        in_value = v; in_blank_mask = b; in_blink_mask = k; in_valid = 1;
        for (int n = 0; n < 64; n++) begin
            if (in_ready) begin
                step(1);
                in_valid = 0;
                return;
            end
            step(1);
        end
        in_valid = 0;
        check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_sel(input logic [5:0] target);
        for (int n = 0; n < 40; n++) begin
            if (scan_sel == target) return;
            step(1);
        end
        check("wait_sel_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [23:0] v;
        logic [6:0]  cur, prev;
        logic [5:0]  cs, ps;
        int          run, lit;
        bit          seen, found;

        step(2);
        check("rst_seg_out", 64'(seg_out), 64'({6{DK}}));
        check("rst_scan_seg", 64'(scan_seg), 64'(DK));
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_scan_sel", 64'(scan_sel), 64'd0);
        reset_n = 1;
        step(1);

        send(24'h0123AF, 6'b0, 6'b0);
        check("t1_ready_low", 64'(in_ready), 64'd0);
        step(1);
        check("t1_ready_back", 64'(in_ready), 64'd1);
        check("t1_latency", 64'(seg_out[6:0]), 64'(DK));
        step(1);
        check("t1_d0", 64'(seg_out[6:0]), 64'(7'b0001110));
        check("t1_d1", 64'(seg_out[13:7]), 64'(7'b0001000));
        check("t1_d5", 64'(seg_out[41:35]), 64'(7'b1000000));

        lz_blank = 1;
        send(24'h000050, 6'b0, 6'b0);
        step(2);
        check("t2_high_dark", 64'(seg_out[41:14]), 64'({4{DK}}));
        check("t2_d1", 64'(seg_out[13:7]), 64'(7'b0010010));
        check("t2_d0", 64'(seg_out[6:0]), 64'(7'b1000000));
        send(24'h0, 6'b0, 6'b0);
        step(2);
        check("t2_zero", 64'(seg_out), 64'({{5{DK}}, 7'b1000000}));

        lz_blank = 0;
        send(24'h000008, 6'b0, 6'b000001);
        step(2);
        prev = seg_out[6:0]; run = 1; seen = 0; lit = 0;
        for (int n = 0; n < 32; n++) begin
            step(1);
            cur = seg_out[6:0];
            if (cur == 7'h00) lit++;
            if (cur != prev) begin
                if (seen) check("t3_run", 64'(run), 64'd8);
                seen = 1; run = 1; prev = cur;
            end else run++;
        end
        check("t3_lit", 64'(lit), 64'd16);
        check("t3_d1", 64'(seg_out[13:7]), 64'(7'b1000000));

        v = 24'h0123AF;
        send(v, 6'b0, 6'b0);
        step(2);
        mode_scan = 1;
        step(1);
        check("t4_static_dark", 64'(seg_out), 64'({6{DK}}));
        ps = scan_sel; run = 1; seen = 0;
        for (int n = 0; n < 30; n++) begin
            step(1);
            cs = scan_sel;
            check("t4_onehot", 64'($onehot(cs)), 64'd1);
            check("t4_seg", 64'(scan_seg), 64'(ENC[v[4*sel_idx(cs) +: 4]]));
            if (cs != ps) begin
                check("t4_step", 64'(cs), 64'({ps[4:0], ps[5]}));
                if (seen) check("t4_dwell", 64'(run), 64'd4);
                seen = 1; run = 1; ps = cs;
            end else run++;
        end

        wait_sel(6'b000100);
        in_value = 24'h456789; in_blank_mask = '0; in_blink_mask = '0; in_valid = 1;
        step(1);
        check("t5_accept", 64'(in_ready), 64'd0);
        in_value = 24'hABCDEF;
        found = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            step(1);
            if (in_ready) found = 1;
            else check("t5_old_frame", 64'(scan_seg), 64'(ENC[v[4*sel_idx(scan_sel) +: 4]]));
        end
        check("t5_boundary", 64'(found), 64'd1);
        check("t5_sel_last", 64'(scan_sel), 64'(6'b100000));
        check("t5_seg_last", 64'(scan_seg), 64'(7'b1000000));
        step(1);
        check("t5_second_accept", 64'(in_ready), 64'd0);
        check("t5_sel_first", 64'(scan_sel), 64'(6'b000001));
        check("t5_new_d0", 64'(scan_seg), 64'(7'b0010000));
        in_valid = 0;

        @(posedge clk);
        #2 reset_n = 0;
        #1;
        check("t6_seg_out", 64'(seg_out), 64'({6{DK}}));
        check("t6_scan_seg", 64'(scan_seg), 64'(DK));
        check("t6_in_ready", 64'(in_ready), 64'd1);
        check("t6_scan_sel", 64'(scan_sel), 64'(6'b000001));
        step(2);
        reset_n = 1;
        for (int n = 0; n < 60; n++) begin
            step(1);
            check("t6_discarded", 64'(scan_seg), 64'(DK));
        end

        wait_sel(6'b000100);
        send(24'h111111, 6'b0, 6'b0);
        check("t7_pending", 64'(in_ready), 64'd0);
        mode_scan = 0;
        step(1);
        check("t7_apply", 64'(in_ready), 64'd1);
        step(1);
        check("t7_seg_out", 64'(seg_out), 64'({6{7'b1111001}}));
        check("t7_scan_sel", 64'(scan_sel), 64'd0);
        check("t7_scan_seg", 64'(scan_seg), 64'(DK));

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
Parametrised 7-segment display controller for the board-level hex LED outputs.
- Takes a packed hex value through a valid/ready handshake.
- Supports per-digit blanking, per-digit blinking and leading-zero suppression.
- Drives either static per-digit segment buses or a single time-multiplexed segment bus with digit selects, for boards with scanned displays.
- Sits between the core's hex-LED export and the board pins; segment encoding is the team's standard active-low gfedcba table.

Parameters:
DIGITS, 6, number of digits (1..8)
BLINK_DIV, 24, blink phase toggles every 2^(BLINK_DIV-1) clocks (full period 2^BLINK_DIV)
SCAN_DIV, 16, scan dwell per digit = 2^SCAN_DIV clocks
ACTIVE_LOW, 1, 1: segment outputs active-low (lit = 0); 0: inverted

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  new display data offered
in_ready  output  1  controller can accept data
in_value  input  4*DIGITS  hex nibbles, digit 0 = bits [3:0]
in_blank_mask  input  DIGITS  1 = digit forced dark
in_blink_mask  input  DIGITS  1 = digit blinks
lz_blank  input  1  leading-zero suppression enable (level, sampled every cycle)
mode_scan  input  1  0 = static outputs, 1 = multiplexed (level, sampled every cycle)
seg_out  output  7*DIGITS  static segments, digit i = bits [7i+6:7i]
scan_seg  output  7  multiplexed segment bus
scan_sel  output  DIGITS  one-hot active-high digit select

Behaviour:
- Clock is clk. Reset is asynchronous, active-low on reset_n. There is one clock domain.
- Reset values:
  - Displayed value regs = 0.
  - Displayed blank mask = all ones.
  - Displayed blink mask = 0.
  - Pending register empty; in_ready = 1.
  - Blink counter and scan counter = 0; digit index = 0.
  - seg_out all dark; scan_seg dark.
  - scan_sel = 0 in static mode, or one-hot digit 0 in scan mode.
- Dark = 7'b1111111 when ACTIVE_LOW=1, else 7'b0000000.
- Handshake:
  - Accept on a rising edge when in_valid & in_ready.
  - At acceptance, value and masks are captured into the pending register.
  - in_ready = !pending_full. At most one pending transfer; no data is dropped.
- Apply (pending → displayed, pending cleared):
  - Static mode: on the edge after acceptance. in_ready is low for exactly 1 cycle.
  - Scan mode: only at a frame boundary, i.e. the edge where the digit index wraps DIGITS-1 → 0. This prevents tearing.
  - An accept on the boundary edge itself is applied at the next boundary.
  - If mode_scan falls while pending, apply on the next edge.
- Digit visibility: a digit is dark if any of the following holds:
  - its blank mask bit is set;
  - its blink mask bit is set and blink_phase = 1;
  - lz_blank = 1 and the digit and all higher digits are nibble 0.
  - Digit 0 is never leading-zero suppressed, so value 0 shows "0".
  - Otherwise the digit shows the encoded nibble.
- Encoding (ACTIVE_LOW=1, bits gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1011000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. With ACTIVE_LOW=0 the bitwise inverse is used.
- Blink: BLINK_DIV-bit free-running counter; blink_phase = its MSB. It wraps naturally and is never reset by data updates.
- Scan:
  - SCAN_DIV-bit counter runs in both modes.
  - On its wrap, the digit index increments modulo DIGITS. Non-power-of-2 DIGITS wraps explicitly to 0.
- Outputs are registered and reflect the displayed regs of the previous edge.
  - Static-mode latency: accept edge T, apply T+1, seg_out valid after edge T+2.
  - Static mode: scan_sel = 0, scan_seg dark, seg_out live.
  - Scan mode: seg_out all dark; scan_seg = digit[index]; scan_sel = 1<<index.
  - Mode change takes effect on outputs 1 edge after the mode_scan change.
- Reset asserted mid-operation: all state returns to reset values immediately. The pending transfer is discarded.

Test Plan:
Bench parameters: DIGITS=6, BLINK_DIV=4, SCAN_DIV=2, ACTIVE_LOW=1.
1. Reset then static mode, send in_value=24'h0123AF, masks 0, lz_blank=0 -> in_ready low 1 cycle; 2 edges after accept seg_out digit0=0001110, digit1=0001000, digit5=1000000.
2. lz_blank=1, in_value=24'h000050 -> digits 5..2 dark (1111111), digit1=0010010, digit0=1000000; in_value=0 -> only digit0 lit, showing 1000000.
3. in_blink_mask=6'b000001, value 24'h000008 -> digit0 alternates 0000000 / dark every 8 clocks; other digits unaffected.
4. Scan mode: scan_sel walks 000001→000010→…→100000→000001, dwell 4 clocks each; scan_seg matches the selected digit; seg_out all dark.
5. Scan mode, accept mid-frame -> in_ready stays low until the 100000→000001 boundary edge; displayed data changes only in the new frame; a second in_valid held high is accepted the cycle after in_ready returns high.
6. Assert reset_n low while pending in scan mode -> outputs dark at once, in_ready=1; after release, previous pending data is never displayed.
